// File: rtl/bm_dl_serial_nibble_adder_sequencer_pkg.sv
// Shared constants and types for the serial nibble adder sequencer.
// Holds the FSM state encoding and the nibble width.
package bm_dl_serial_nibble_adder_sequencer_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Nibble counter width; a single-nibble build still needs one bit.
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/bm_dl_serial_nibble_adder_sequencer_if.sv
// Operand/result handshake bundle for the serial nibble adder sequencer.
// Width follows NIBBLES; the master drives operands and out_ready.
interface bm_dl_serial_nibble_adder_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         carryin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         busy;

  modport master (
    output in_valid, x, y, carryin, out_ready,
    input  in_ready, out_valid, sum, carryout, busy
  );

  modport slave (
    input  in_valid, x, y, carryin, out_ready,
    output in_ready, out_valid, sum, carryout, busy
  );

endinterface

// File: rtl/bm_dl_serial_nibble_adder_sequencer_nibble_adder4.sv
// Purely combinational 4-bit ripple-carry adder built from four full-adder cells.
module nibble_adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/bm_dl_serial_nibble_adder_sequencer.sv
// Serial wide adder: streams one nibble per cycle through nibble_adder4, LSB first,
// chaining the carry through a register and presenting the assembled sum on a handshake.
module bm_dl_serial_nibble_adder_sequencer
  import bm_dl_serial_nibble_adder_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic clock,
  input  logic reset,
  bm_dl_serial_nibble_adder_sequencer_if.slave bus
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  seq_state_e        state;
  logic [W-1:0]      x_sh;
  logic [W-1:0]      y_sh;
  logic [W-1:0]      sum_sh;
  logic [W-1:0]      sum_nxt;
  logic              carry_r;
  logic [CW-1:0]     cnt;
  logic              cout_r;
  logic              ovld_r;
  logic [NIB_W-1:0]  s4;
  logic              c4;

  nibble_adder4 u_add (
    .x    (x_sh[NIB_W-1:0]),
    .y    (y_sh[NIB_W-1:0]),
    .cin  (carry_r),
    .s    (s4),
    .cout (c4)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 lands at the bottom.
  if (NIBBLES == 1) begin : g_one
    assign sum_nxt = s4;
  end else begin : g_many
    assign sum_nxt = {s4, sum_sh[W-1:NIB_W]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      x_sh    <= '0;
      y_sh    <= '0;
      sum_sh  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      cout_r  <= 1'b0;
      ovld_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_sh    <= bus.x;
            y_sh    <= bus.y;
            carry_r <= bus.carryin;
            cnt     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          x_sh    <= x_sh >> NIB_W;
          y_sh    <= y_sh >> NIB_W;
          sum_sh  <= sum_nxt;
          carry_r <= c4;
          if (cnt == CNT_LAST) begin
            cout_r <= c4;
            ovld_r <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ovld_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = ovld_r;
  assign bus.sum       = sum_sh;
  assign bus.carryout  = cout_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_bm_dl_serial_nibble_adder_sequencer.sv
// Self-checking bench: directed and random operand pairs against an arithmetic model,
// plus backpressure, mid-operation reset and a single-nibble back-to-back run.
module tb_bm_dl_serial_nibble_adder_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bm_dl_serial_nibble_adder_sequencer_if #(.NIBBLES(4)) b4 ();
  bm_dl_serial_nibble_adder_sequencer_if #(.NIBBLES(1)) b1 ();

  bm_dl_serial_nibble_adder_sequencer #(.NIBBLES(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (b4)
  );

  bm_dl_serial_nibble_adder_sequencer #(.NIBBLES(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  // One full transaction on the 4-nibble instance, with `hold` stalled DONE cycles.
  task automatic run_op(input logic [15:0] a, input logic [15:0] bb, input logic c,
                        input int hold);
    logic [16:0] e;
    int n;
    e = ref_add(a, bb, c);
    chk("in_ready_idle", b4.in_ready, 1);
    b4.in_valid  = 1'b1;
    b4.x         = a;
    b4.y         = bb;
    b4.carryin   = c;
    b4.out_ready = 1'b0;
    tick();
    b4.in_valid = 1'b0;
    b4.x        = 16'($urandom);
    b4.y        = 16'($urandom);
    n = 0;
    while (!b4.out_valid && n < 40) begin
      chk("in_ready_add", b4.in_ready, 0);
      tick();
      n++;
    end
    chk("latency", n, 4);
    chk("sum", b4.sum, e[15:0]);
    chk("carryout", b4.carryout, e[16]);
    chk("busy_done", b4.busy, 1);
    for (int h = 0; h < hold; h++) begin
      b4.in_valid = 1'b1;
      b4.x        = 16'($urandom);
      b4.y        = 16'($urandom);
      chk("bp_in_ready", b4.in_ready, 0);
      tick();
      chk("bp_valid", b4.out_valid, 1);
      chk("bp_sum", b4.sum, e[15:0]);
      chk("bp_cout", b4.carryout, e[16]);
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;
    chk("ov_clear", b4.out_valid, 0);
    chk("in_ready_after", b4.in_ready, 1);
    chk("busy_idle", b4.busy, 0);
  endtask

  initial begin
    int seen;
    int acc_q[$];
    logic [4:0] e1;

    reset = 1'b1;
    b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.carryin = 1'b0; b4.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.x = '0; b1.y = '0; b1.carryin = 1'b0; b1.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_sum", b4.sum, 0);
    chk("rst_carryout", b4.carryout, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_in_ready", b4.in_ready, 0);
    chk("rst1_in_ready", b1.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", b4.in_ready, 1);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 3);

    for (int i = 0; i < 20; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // Reset lands in the second ADD cycle; the pair must vanish without a result.
    b4.in_valid = 1'b1; b4.x = 16'h1111; b4.y = 16'h2222; b4.carryin = 1'b0;
    tick();
    b4.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", b4.out_valid, 0);
    chk("mid_rst_busy", b4.busy, 0);
    chk("mid_rst_sum", b4.sum, 0);
    chk("mid_rst_in_ready", b4.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("mid_rel_in_ready", b4.in_ready, 1);
    b4.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b4.out_valid) seen++;
    end
    b4.out_ready = 1'b0;
    chk("no_abort_result", seen, 0);

    // Single-nibble instance: held request, tied out_ready, accept every 3 cycles.
    e1 = 5'd9 + 5'd8;
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    b1.x         = 4'h9;
    b1.y         = 4'h8;
    b1.carryin   = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (b1.in_ready) acc_q.push_back(cyc);
      if (b1.out_valid) begin
        chk("n1_sum", b1.sum, e1[3:0]);
        chk("n1_cout", b1.carryout, e1[4]);
      end
      tick();
    end
    b1.in_valid = 1'b0;
    chk("n1_accepts", (acc_q.size() >= 4), 1);
    for (int i = 1; i < acc_q.size(); i++)
      chk("n1_interval", acc_q[i] - acc_q[i-1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bm_dl_serial_nibble_adder_sequencer.md
Name: bm_DL_serial_nibble_adder_sequencer

Overview:
- Upstream operand sequencer for the 4-bit ripple-carry adder stage.
- Accepts a wide operand pair over a valid/ready handshake and feeds one 4-bit nibble per cycle through a 4-bit adder datapath, LSB nibble first.
- Chains the carry through a register between nibbles, assembles the wide sum, and presents sum and carryout over a valid/ready output handshake.
- Lets the MICROBENCHMARKS suite exercise a sequential, multi-cycle use of the nibble adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair (x, y, carryin) is valid this cycle.
- in_ready  output  1  sequencer can accept operands this cycle.
- x  input  W  operand X.
- y  input  W  operand Y.
- carryin  input  1  carry into nibble 0.
- out_valid  output  1  sum and carryout are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  W  X + Y + carryin, low W bits.
- carryout  output  1  carry out of the top nibble.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset values, on any edge with reset=1:
  - state=IDLE; out_valid=0, sum=0, carryout=0, busy=0.
  - Internal shift registers, carry and nibble counter all cleared to 0.
  - in_ready is forced 0 while reset is high.
- Reset takes priority over every other event, including mid-ADD and mid-DONE. An in-flight operation is discarded with no output.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x_sh<=x, y_sh<=y, carry_r<=carryin, cnt<=0, go to ADD.
  - Otherwise hold.
- ADD, one nibble per cycle:
  - {c,s4} = x_sh[3:0] + y_sh[3:0] + carry_r, computed by the 4-bit adder sub-module (5-bit result).
  - x_sh and y_sh shift right by 4, zero-filled.
  - sum_sh <= {s4, sum_sh[W-1:4]}; carry_r<=c; cnt<=cnt+1.
  - When cnt==NIBBLES-1: carryout<=c and go to DONE; sum takes the final shifted value.
  - in_ready=0; inputs are ignored.
- DONE:
  - out_valid=1; sum and carryout are held stable until handshake.
  - On out_ready=1: go to IDLE; out_valid=0 next cycle.
  - in_ready=0 throughout DONE. There is no same-cycle accept on the output handshake; the earliest new accept is the cycle after the output handshake.
- Latency:
  - Accept at edge k → out_valid high after edge k+NIBBLES.
  - Minimum initiation interval is NIBBLES+2 cycles when out_ready is held high.
- Width rules:
  - cnt width = clog2(NIBBLES), minimum 1 bit.
  - cnt wraps only via reload on accept; it never exceeds NIBBLES-1.
- NIBBLES=1: ADD lasts exactly one cycle.
- The sum register is updated only in ADD. It keeps the last result in IDLE; consumers must qualify it with out_valid.
- in_ready is a pure function of state and reset, with no combinational path from in_valid.
- out_valid is registered, with no combinational path from out_ready.

Decomposition:
- Shared header (`include`d defines/localparams):
  - state encodings IDLE=2'd0, ADD=2'd1, DONE=2'd2;
  - nibble width constant NIB_W=4.
- One sub-module: nibble_adder4.
  - Purely combinational: 4-bit x, 4-bit y, cin → 4-bit s, cout.
  - Built as a chain of four full-adder bit cells.
  - Instantiated once in the ADD datapath.

Test Plan:
- Sum and latency: NIBBLES=4, accept x=16'h1234, y=16'h4321, carryin=0 → out_valid 4 cycles after accept edge, sum=16'h5555, carryout=0.
- Full carry ripple via x: x=16'hFFFF, y=16'h0001, carryin=0 → sum=16'h0000, carryout=1. The carry chains through all 4 nibbles.
- Full carry ripple via carryin: x=16'hFFFF, y=16'h0000, carryin=1 → sum=16'h0000, carryout=1.
- Backpressure:
  - Stimulus: x=16'hA5A5, y=16'h5A5A, carryin=1; hold out_ready=0 for 3 cycles in DONE, with in_valid held high and different x/y applied.
  - Required response: sum=16'h0000, carryout=1, both stable; in_ready=0 throughout; the new operands are not accepted.
  - After out_ready=1, in_ready=1 on the following cycle.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle on the 2nd ADD cycle.
  - Required response: next cycle out_valid=0, busy=0, sum=0, in_ready=1 once reset is low; no result is ever presented for the aborted pair.
- Back-to-back with NIBBLES=1:
  - Stimulus: out_ready tied 1; in_valid held with x=4'h9, y=4'h8, carryin=0.
  - Required response: sum=4'h1, carryout=1; a new accept every 3 cycles.
